// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the 9-bit-ISA control sequencer and its datapath.
package seq_ctrl_pkg;

    // Opcodes, IR[8:5]
    localparam logic [3:0] OP_LDB  = 4'b1000;
    localparam logic [3:0] OP_STB  = 4'b1001;
    localparam logic [3:0] OP_LDH  = 4'b1010;
    localparam logic [3:0] OP_LDL  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_BZ   = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Write-back mux source select
    localparam logic [1:0] WS_ALU  = 2'd0;
    localparam logic [1:0] WS_MEM  = 2'd1;
    localparam logic [1:0] WS_IMM4 = 2'd2;
    localparam logic [1:0] WS_IMM5 = 2'd3;

    // Nine states need four bits
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_NEXT   = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Write-back source for an instruction that retires through WB
    function automatic logic [1:0] wb_sel(input logic [3:0] op);
        logic [1:0] sel;
        case (op)
            OP_LDB:         sel = WS_MEM;
            OP_LDH, OP_LDL: sel = WS_IMM4;
            OP_MOV:         sel = WS_IMM5;
            default:        sel = WS_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seq_ctrl_mem_handshake_timer.sv
// Wait counter for the data-memory req/ack handshake. Counts cycles spent
// waiting for an ack and flags a timeout; an ack in the timeout cycle wins.
module mem_handshake_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_ack,
    output logic o_ack_done,
    output logic o_timeout
);

    logic [7:0] r_cnt;
    logic       w_last;

    // The cycle whose missing ack would make the count reach MEM_TIMEOUT
    assign w_last     = (r_cnt == 8'(MEM_TIMEOUT - 1));
    assign o_ack_done = i_active & i_ack;
    assign o_timeout  = i_active & ~i_ack & w_last;

    // Count unacknowledged request cycles; idle clears so each entry starts at 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_active) begin
            r_cnt <= 8'd0;
        end else if (!i_ack) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle control sequencer: fetches, decodes and steps the PC,
// register file, data memory and write-back mux per opcode.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [8:0]       Instruction,
    input  logic             Zero,
    input  logic             MemAck,
    output logic [8:0]       IR,
    output logic             PcInc,
    output logic             PcLoad,
    output logic             PcClear,
    output logic             RegWrite,
    output logic [1:0]       WriteSel,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] InstCount
);

    state_t           r_state;
    logic [8:0]       r_ir;
    logic [1:0]       r_wsel;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    state_t     w_nxt;
    logic [3:0] w_op;
    logic       w_mem_active;
    logic       w_ack_done;
    logic       w_timeout;
    logic       w_retire;

    assign w_op         = r_ir[8:5];
    assign w_mem_active = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    mem_handshake_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_active   (w_mem_active),
        .i_ack      (MemAck),
        .o_ack_done (w_ack_done),
        .o_timeout  (w_timeout)
    );

    // Retirement points: the three terminal states, plus the halt on its way in
    assign w_retire = (r_state == S_WB) || (r_state == S_NEXT) ||
                      (r_state == S_BRANCH) ||
                      ((r_state == S_DECODE) && (w_op == OP_HALT));

    // Next-state selection
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (Start) w_nxt = S_FETCH;
            S_FETCH:  w_nxt = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LDB:  w_nxt = S_MEM_RD;
                    OP_STB:  w_nxt = S_MEM_WR;
                    OP_BZ:   w_nxt = S_BRANCH;
                    OP_HALT: w_nxt = S_HALT;
                    default: w_nxt = S_WB;
                endcase
            end
            S_MEM_RD: begin
                if (w_ack_done)     w_nxt = S_WB;
                else if (w_timeout) w_nxt = S_HALT;
            end
            S_MEM_WR: begin
                if (w_ack_done)     w_nxt = S_NEXT;
                else if (w_timeout) w_nxt = S_HALT;
            end
            S_WB, S_NEXT, S_BRANCH: w_nxt = S_FETCH;
            S_HALT:   if (Start) w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // State, instruction latch, write-back select, sticky fault and retire count
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_ir    <= 9'd0;
            r_wsel  <= WS_ALU;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_FETCH) r_ir <= Instruction;
            // Select is set on entry to WB and then held until the next WB
            if ((r_state == S_DECODE) && (w_nxt == S_WB)) r_wsel <= wb_sel(w_op);
            if ((r_state == S_MEM_RD) && w_ack_done)      r_wsel <= WS_MEM;
            if (w_timeout) r_err <= 1'b1;
            if (w_retire && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Moore strobe decode; forced low while reset is held
    always_comb begin
        PcInc    = 1'b0;
        PcLoad   = 1'b0;
        PcClear  = 1'b0;
        RegWrite = 1'b0;
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        if (Reset_n) begin
            case (r_state)
                S_IDLE:   PcClear = 1'b1;
                S_MEM_RD: MemReq  = 1'b1;
                S_MEM_WR: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PcInc    = 1'b1;
                end
                S_NEXT:   PcInc = 1'b1;
                S_BRANCH: begin
                    PcLoad = Zero;
                    PcInc  = ~Zero;
                end
                default: ;
            endcase
        end
    end

    assign IR        = r_ir;
    assign WriteSel  = r_wsel;
    assign Done      = (r_state == S_HALT);
    assign Err       = r_err;
    assign InstCount = r_cnt;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: one task per scenario, hand-computed values.
// InstCount is built 3 bits wide so saturation at 7 is reachable.
module tb_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n, Start, Zero, MemAck;
    logic [8:0] Instruction;
    logic [8:0] IR;
    logic       PcInc, PcLoad, PcClear, RegWrite, MemReq, MemWrite, Done, Err;
    logic [1:0] WriteSel;
    logic [2:0] InstCount;

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] I_RTYPE = 9'b0000_00011;
    localparam logic [8:0] I_LDB   = 9'b1000_00010;
    localparam logic [8:0] I_STB   = 9'b1001_00000;
    localparam logic [8:0] I_LDH   = 9'b1010_01010;
    localparam logic [8:0] I_MOV   = 9'b0111_10101;
    localparam logic [8:0] I_BZ    = 9'b1100_00000;
    localparam logic [8:0] I_HALT  = 9'b1111_00000;

    seq_ctrl #(.MEM_TIMEOUT(15), .CNT_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
        .Zero(Zero), .MemAck(MemAck), .IR(IR), .PcInc(PcInc), .PcLoad(PcLoad),
        .PcClear(PcClear), .RegWrite(RegWrite), .WriteSel(WriteSel),
        .MemReq(MemReq), .MemWrite(MemWrite), .Done(Done), .Err(Err),
        .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Start = 1'b0; Zero = 1'b0; MemAck = 1'b0; Instruction = '0;
        #12;
        checks++; if (IR !== 9'd0) begin failures++; $display("FAIL reset_ir got=%h exp=0", IR); end
        checks++; if (InstCount !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", InstCount); end
        checks++; if (Err !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL reset_err_done got=%b%b exp=00", Err, Done); end
        checks++; if ({PcInc, PcLoad, PcClear, RegWrite, MemReq, MemWrite} !== 6'b0 || WriteSel !== 2'd0)
            begin failures++; $display("FAIL reset_strobes got=%b%b%b%b%b%b ws=%0d exp=0", PcInc, PcLoad, PcClear, RegWrite, MemReq, MemWrite, WriteSel); end
        @(posedge Clk); #1 Reset_n = 1'b1;
        tick;
        checks++; if (PcClear !== 1'b1 || PcInc !== 1'b0) begin failures++; $display("FAIL idle_pcclear got=%b inc=%b exp=1/0", PcClear, PcInc); end
    endtask

    task automatic test_rtype;
        Instruction = I_RTYPE; Start = 1'b1;
        tick; Start = 1'b0;                                 // FETCH
        checks++; if (PcClear !== 1'b0 || PcInc !== 1'b0) begin failures++; $display("FAIL rt_fetch got clr=%b inc=%b exp=0/0", PcClear, PcInc); end
        tick;                                               // DECODE
        checks++; if (IR !== I_RTYPE || RegWrite !== 1'b0 || PcInc !== 1'b0)
            begin failures++; $display("FAIL rt_decode got ir=%h rw=%b inc=%b exp ir=%h rw=0 inc=0", IR, RegWrite, PcInc, I_RTYPE); end
        tick;                                               // WB
        checks++; if (RegWrite !== 1'b1 || WriteSel !== 2'd0 || PcInc !== 1'b1 || PcLoad !== 1'b0)
            begin failures++; $display("FAIL rt_wb got rw=%b ws=%0d inc=%b ld=%b exp 1/0/1/0", RegWrite, WriteSel, PcInc, PcLoad); end
        tick;                                               // FETCH
        checks++; if (RegWrite !== 1'b0 || PcInc !== 1'b0 || InstCount !== 3'd1)
            begin failures++; $display("FAIL rt_retire got rw=%b inc=%b cnt=%0d exp 0/0/1", RegWrite, PcInc, InstCount); end
    endtask

    task automatic test_ldb;
        int n = 0;
        logic wr_seen = 1'b0;
        Instruction = I_LDB;
        tick; tick;                                         // DECODE, MEM_RD
        while (MemReq === 1'b1 && n < 40) begin
            n++;
            if (MemWrite !== 1'b0) wr_seen = 1'b1;
            if (n == 4) MemAck = 1'b1;
            tick;
            MemAck = 1'b0;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL ldb_req_cycles got=%0d exp=4", n); end
        checks++; if (wr_seen !== 1'b0) begin failures++; $display("FAIL ldb_memwrite got=1 exp=0"); end
        checks++; if (RegWrite !== 1'b1 || WriteSel !== 2'd1) begin failures++; $display("FAIL ldb_wb got rw=%b ws=%0d exp 1/1", RegWrite, WriteSel); end
        tick;
        checks++; if (InstCount !== 3'd2) begin failures++; $display("FAIL ldb_cnt got=%0d exp=2", InstCount); end
    endtask

    task automatic test_ldh_mov;
        Instruction = I_LDH;
        tick; tick;                                         // DECODE, WB
        checks++; if (RegWrite !== 1'b1 || WriteSel !== 2'd2) begin failures++; $display("FAIL ldh_wb got rw=%b ws=%0d exp 1/2", RegWrite, WriteSel); end
        tick;                                               // FETCH
        checks++; if (RegWrite !== 1'b0 || WriteSel !== 2'd2) begin failures++; $display("FAIL ldh_hold got rw=%b ws=%0d exp 0/2", RegWrite, WriteSel); end
        Instruction = I_MOV;
        tick;                                               // DECODE
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL mov_decode got rw=%b exp=0", RegWrite); end
        tick;                                               // WB
        checks++; if (RegWrite !== 1'b1 || WriteSel !== 2'd3) begin failures++; $display("FAIL mov_wb got rw=%b ws=%0d exp 1/3", RegWrite, WriteSel); end
        tick;
        checks++; if (RegWrite !== 1'b0 || InstCount !== 3'd4) begin failures++; $display("FAIL mov_retire got rw=%b cnt=%0d exp 0/4", RegWrite, InstCount); end
    endtask

    task automatic test_branch;
        Zero = 1'b1; Instruction = I_BZ;
        tick; tick;                                         // DECODE, BRANCH
        checks++; if (PcLoad !== 1'b1 || PcInc !== 1'b0 || RegWrite !== 1'b0)
            begin failures++; $display("FAIL bz_taken got ld=%b inc=%b rw=%b exp 1/0/0", PcLoad, PcInc, RegWrite); end
        tick; Zero = 1'b0;                                  // FETCH
        tick; tick;                                         // DECODE, BRANCH
        checks++; if (PcLoad !== 1'b0 || PcInc !== 1'b1 || RegWrite !== 1'b0)
            begin failures++; $display("FAIL bz_not_taken got ld=%b inc=%b rw=%b exp 0/1/0", PcLoad, PcInc, RegWrite); end
        tick;
        checks++; if (InstCount !== 3'd6) begin failures++; $display("FAIL bz_cnt got=%0d exp=6", InstCount); end
    endtask

    task automatic test_halt;
        Instruction = I_HALT;
        tick; tick;                                         // DECODE, HALT
        checks++; if (Done !== 1'b1 || InstCount !== 3'd7) begin failures++; $display("FAIL halt_entry got done=%b cnt=%0d exp 1/7", Done, InstCount); end
        checks++; if ({PcInc, PcLoad, PcClear, RegWrite, MemReq} !== 5'b0) begin failures++; $display("FAIL halt_strobes got=%b%b%b%b%b exp=0", PcInc, PcLoad, PcClear, RegWrite, MemReq); end
        tick;
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b exp=1", Done); end
        Start = 1'b1; tick; Start = 1'b0;                   // IDLE
        checks++; if (Done !== 1'b0 || PcClear !== 1'b1) begin failures++; $display("FAIL halt_restart got done=%b clr=%b exp 0/1", Done, PcClear); end
    endtask

    task automatic test_saturate;
        Instruction = I_RTYPE; Start = 1'b1;
        tick; Start = 1'b0;
        tick; tick; tick;                                   // DECODE, WB, FETCH
        checks++; if (InstCount !== 3'd7) begin failures++; $display("FAIL cnt_saturate got=%0d exp=7", InstCount); end
    endtask

    task automatic test_start_ignored_reset;
        Instruction = I_LDB;
        tick; Start = 1'b1;                                 // DECODE with Start
        tick;                                               // MEM_RD
        checks++; if (MemReq !== 1'b1 || PcClear !== 1'b0) begin failures++; $display("FAIL start_in_decode got req=%b clr=%b exp 1/0", MemReq, PcClear); end
        tick;
        checks++; if (MemReq !== 1'b1 || PcClear !== 1'b0) begin failures++; $display("FAIL start_in_memrd got req=%b clr=%b exp 1/0", MemReq, PcClear); end
        Start = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (MemReq !== 1'b0 || InstCount !== 3'd0 || IR !== 9'd0)
            begin failures++; $display("FAIL async_reset got req=%b cnt=%0d ir=%h exp 0/0/0", MemReq, InstCount, IR); end
        @(posedge Clk); #1 Reset_n = 1'b1;
        tick;
        checks++; if (PcClear !== 1'b1) begin failures++; $display("FAIL reset_to_idle got clr=%b exp=1", PcClear); end
    endtask

    task automatic test_ack_at_timeout;
        int n = 0;
        Start = 1'b1; tick; Start = 1'b0;                   // FETCH
        Instruction = I_LDB;
        tick; tick;                                         // DECODE, MEM_RD
        while (MemReq === 1'b1 && n < 40) begin
            n++;
            if (n == 15) MemAck = 1'b1;
            tick;
            MemAck = 1'b0;
        end
        checks++; if (n != 15) begin failures++; $display("FAIL ack_edge_cycles got=%0d exp=15", n); end
        checks++; if (Err !== 1'b0 || RegWrite !== 1'b1 || WriteSel !== 2'd1)
            begin failures++; $display("FAIL ack_edge_wb got err=%b rw=%b ws=%0d exp 0/1/1", Err, RegWrite, WriteSel); end
        tick;                                               // FETCH
    endtask

    task automatic test_timeout;
        int n = 0;
        logic wr_miss = 1'b0;
        Instruction = I_STB;
        tick; tick;                                         // DECODE, MEM_WR
        while (MemReq === 1'b1 && n < 40) begin
            n++;
            if (MemWrite !== 1'b1) wr_miss = 1'b1;
            tick;
        end
        checks++; if (n != 15) begin failures++; $display("FAIL to_req_cycles got=%0d exp=15", n); end
        checks++; if (wr_miss !== 1'b0) begin failures++; $display("FAIL to_memwrite got=0 exp=1"); end
        checks++; if (Err !== 1'b1 || Done !== 1'b1) begin failures++; $display("FAIL to_fault got err=%b done=%b exp 1/1", Err, Done); end
        tick; tick;
        checks++; if (Err !== 1'b1 || Done !== 1'b1 || MemReq !== 1'b0) begin failures++; $display("FAIL to_hold got err=%b done=%b req=%b exp 1/1/0", Err, Done, MemReq); end
        Start = 1'b1; tick; Start = 1'b0;                   // IDLE
        checks++; if (Err !== 1'b1 || Done !== 1'b0 || PcClear !== 1'b1) begin failures++; $display("FAIL to_restart got err=%b done=%b clr=%b exp 1/0/1", Err, Done, PcClear); end
        Reset_n = 1'b0; #1;
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", Err); end
        @(posedge Clk); #1 Reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_ldb;
        test_ldh_mov;
        test_branch;
        test_halt;
        test_saturate;
        test_start_ignored_reset;
        test_ack_at_timeout;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
